// File: rtl/fm_sb_capture.sv
// Spy-buffer capture/playback engine: packs a tapped stream into a circular
// memory, freezes on trigger, and exposes the memory via a 32-bit word port.
module fm_sb_capture #(
  parameter int SB_TP_DW  = 51,
  parameter int SB_DW     = 64,
  parameter int AXI_DW    = 32,
  parameter int ADDR_W    = 10,
  parameter int PB_MODE_W = 2,
  localparam int NSL      = SB_DW / AXI_DW,
  localparam int SL_W     = $clog2(NSL),
  localparam int AA_W     = ADDR_W + SL_W
) (
  input  logic                 spy_clock,
  input  logic                 rst_n,
  input  logic [SB_TP_DW-1:0]  in_data,
  input  logic                 in_vld,
  input  logic [PB_MODE_W-1:0] pb_mode,
  input  logic                 arm,
  input  logic                 trig,
  input  logic [ADDR_W-1:0]    post_count,
  input  logic [ADDR_W-1:0]    pb_last,
  input  logic [AA_W-1:0]      axi_addr,
  input  logic                 axi_rd,
  input  logic                 axi_wr,
  input  logic [AXI_DW-1:0]    axi_wdata,
  output logic [AXI_DW-1:0]    axi_rdata,
  output logic                 axi_rvld,
  output logic [SB_TP_DW-1:0]  pb_data,
  output logic                 pb_vld,
  output logic [ADDR_W-1:0]    wr_ptr,
  output logic [ADDR_W-1:0]    trig_ptr,
  output logic                 wrapped,
  output logic                 capturing,
  output logic                 frozen,
  output logic [2:0]           dbg_state
);

  // Handshake: axi_rvld and pb_vld qualify their data for exactly the cycle
  // they are high; there is no ready, so consumers must take data when valid.

  localparam int SEL_W = (SL_W > 0) ? SL_W : 1;
  localparam logic [PB_MODE_W-1:0] MODE_OFF  = PB_MODE_W'(0);
  localparam logic [PB_MODE_W-1:0] MODE_POST = PB_MODE_W'(2);
  localparam logic [PB_MODE_W-1:0] MODE_PB   = PB_MODE_W'(3);
  localparam logic [SB_DW-1:0]     TP_MASK   = (SB_DW'(1) << SB_TP_DW) - SB_DW'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_CAPTURE, S_POST, S_FROZEN, S_PLAYBACK
  } state_t;

  state_t                 state_q, state_d;
  logic [PB_MODE_W-1:0]   mode_q;
  logic [ADDR_W-1:0]      post_cnt;
  logic [ADDR_W-1:0]      pb_addr;
  logic                   cap_we, arm_cap, arm_pb, trig_hit, post_load;

  logic [SB_DW-1:0]       mem [2**ADDR_W];
  logic [ADDR_W-1:0]      ax_entry;
  logic [SEL_W-1:0]       ax_sel;
  logic                   ax_wr_ok;

  logic [SB_DW-1:0]       rd_word_q;
  logic [SEL_W-1:0]       rd_sel_q;
  logic                   rd_v1;
  logic [SB_TP_DW-1:0]    pb_word_q;
  logic                   pb_v1;

  assign dbg_state = state_q;
  assign ax_entry  = axi_addr[AA_W-1:SL_W];
  assign ax_sel    = SEL_W'(axi_addr % NSL);
  assign ax_wr_ok  = (state_q == S_IDLE) || (state_q == S_FROZEN);

  // Abort beats arm, arm beats trig; a restart never writes in its own cycle.
  always_comb begin
    state_d   = state_q;
    cap_we    = 1'b0;
    arm_cap   = 1'b0;
    arm_pb    = 1'b0;
    trig_hit  = 1'b0;
    post_load = 1'b0;
    if (pb_mode == MODE_OFF) begin
      state_d = S_IDLE;
    end else if (arm) begin
      if (pb_mode == MODE_PB) begin
        state_d = S_PLAYBACK;
        arm_pb  = 1'b1;
      end else begin
        state_d = S_CAPTURE;
        arm_cap = 1'b1;
      end
    end else begin
      case (state_q)
        S_CAPTURE: begin
          cap_we = in_vld;
          if (trig) begin
            trig_hit = 1'b1;
            if (mode_q == MODE_POST && post_count != '0) begin
              state_d   = S_POST;
              post_load = 1'b1;
            end else begin
              state_d = S_FROZEN;
            end
          end
        end
        S_POST: begin
          cap_we = in_vld;
          if (in_vld && post_cnt == ADDR_W'(1)) state_d = S_FROZEN;
        end
        S_PLAYBACK: if (pb_mode != MODE_PB) state_d = S_IDLE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge spy_clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      mode_q    <= '0;
      wr_ptr    <= '0;
      trig_ptr  <= '0;
      wrapped   <= 1'b0;
      post_cnt  <= '0;
      pb_addr   <= '0;
      capturing <= 1'b0;
      frozen    <= 1'b0;
    end else begin
      state_q   <= state_d;
      capturing <= (state_q == S_CAPTURE) || (state_q == S_POST);
      frozen    <= (state_q == S_FROZEN);
      if (arm) mode_q <= pb_mode;
      if (arm_cap) begin
        wr_ptr   <= '0;
        wrapped  <= 1'b0;
        trig_ptr <= '0;
      end else if (cap_we) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
        if (wr_ptr == '1) wrapped <= 1'b1;
      end
      // Trigger-cycle word counts as pre-trigger data.
      if (trig_hit) trig_ptr <= wr_ptr + ADDR_W'(cap_we);
      if (post_load) post_cnt <= post_count;
      else if (cap_we && state_q == S_POST) post_cnt <= post_cnt - ADDR_W'(1);
      if (arm_pb) pb_addr <= '0;
      else if (state_q == S_PLAYBACK) pb_addr <= (pb_addr == pb_last) ? '0 : pb_addr + ADDR_W'(1);
    end
  end

  always_ff @(posedge spy_clock) begin
    if (cap_we) mem[wr_ptr] <= SB_DW'(in_data);
    else if (axi_wr && ax_wr_ok) mem[ax_entry][ax_sel*AXI_DW +: AXI_DW] <= axi_wdata;
  end

  // Two-stage read pipes; bits above the tap width always read back as zero.
  always_ff @(posedge spy_clock or negedge rst_n) begin
    if (!rst_n) begin
      rd_word_q <= '0;
      rd_sel_q  <= '0;
      rd_v1     <= 1'b0;
      axi_rdata <= '0;
      axi_rvld  <= 1'b0;
      pb_word_q <= '0;
      pb_v1     <= 1'b0;
      pb_data   <= '0;
      pb_vld    <= 1'b0;
    end else begin
      rd_v1    <= axi_rd;
      axi_rvld <= rd_v1;
      if (axi_rd) begin
        rd_word_q <= mem[ax_entry] & TP_MASK;
        rd_sel_q  <= ax_sel;
      end
      if (rd_v1) axi_rdata <= rd_word_q[rd_sel_q*AXI_DW +: AXI_DW];
      pb_v1  <= (state_q == S_PLAYBACK);
      pb_vld <= pb_v1;
      if (state_q == S_PLAYBACK) pb_word_q <= mem[pb_addr][SB_TP_DW-1:0];
      if (pb_v1) pb_data <= pb_word_q;
    end
  end

endmodule

// File: tb/tb_fm_sb_capture.sv
// Directed bench for fm_sb_capture with a 16-entry memory; AXI reads and
// playback words are checked by queue-driven monitors.
module tb_fm_sb_capture;
  localparam int TP  = 51;
  localparam int AW  = 4;
  localparam int AAW = 5;

  logic           spy_clock = 1'b0;
  logic           rst_n = 1'b0;
  logic [TP-1:0]  in_data = '0;
  logic           in_vld = 1'b0;
  logic [1:0]     pb_mode = 2'd0;
  logic           arm = 1'b0;
  logic           trig = 1'b0;
  logic [AW-1:0]  post_count = '0;
  logic [AW-1:0]  pb_last = '0;
  logic [AAW-1:0] axi_addr = '0;
  logic           axi_rd = 1'b0;
  logic           axi_wr = 1'b0;
  logic [31:0]    axi_wdata = '0;
  logic [31:0]    axi_rdata;
  logic           axi_rvld;
  logic [TP-1:0]  pb_data;
  logic           pb_vld;
  logic [AW-1:0]  wr_ptr, trig_ptr;
  logic           wrapped, capturing, frozen;
  logic [2:0]     dbg_state;

  fm_sb_capture #(.SB_TP_DW(TP), .SB_DW(64), .AXI_DW(32), .ADDR_W(AW), .PB_MODE_W(2)) dut (
    .spy_clock(spy_clock), .rst_n(rst_n), .in_data(in_data), .in_vld(in_vld),
    .pb_mode(pb_mode), .arm(arm), .trig(trig), .post_count(post_count), .pb_last(pb_last),
    .axi_addr(axi_addr), .axi_rd(axi_rd), .axi_wr(axi_wr), .axi_wdata(axi_wdata),
    .axi_rdata(axi_rdata), .axi_rvld(axi_rvld), .pb_data(pb_data), .pb_vld(pb_vld),
    .wr_ptr(wr_ptr), .trig_ptr(trig_ptr), .wrapped(wrapped), .capturing(capturing),
    .frozen(frozen), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 spy_clock = ~spy_clock;
  int cyc = 0;
  always @(posedge spy_clock) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [31:0]   axi_exp_q[$];
  int            axi_cyc_q[$];
  logic [TP-1:0] pb_exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  always @(negedge spy_clock) begin : mon
    logic [31:0]   ea;
    logic [TP-1:0] ep;
    int            ec;
    if (rst_n && axi_rvld) begin
      if (axi_exp_q.size() == 0) check("axi_unexpected", 64'(axi_rdata), 64'hdead_0000);
      else begin
        ea = axi_exp_q.pop_front();
        ec = axi_cyc_q.pop_front();
        check("axi_rdata", 64'(axi_rdata), 64'(ea));
        check("axi_latency", 64'(cyc), 64'(ec));
      end
    end
    if (rst_n && pb_vld) begin
      if (pb_exp_q.size() == 0) check("pb_unexpected", 64'(pb_data), 64'hdead_0001);
      else begin
        ep = pb_exp_q.pop_front();
        check("pb_data", 64'(pb_data), 64'(ep));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge spy_clock);
      #1;
    end
  endtask

  task automatic do_arm(input logic [1:0] m);
    pb_mode = m; arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic push_word(input logic [TP-1:0] d, input logic t = 1'b0);
    in_data = d; in_vld = 1'b1; trig = t;
    tick();
    in_vld = 1'b0; trig = 1'b0;
  endtask

  task automatic axi_read(input logic [AAW-1:0] a, input logic [31:0] exp);
    axi_addr = a; axi_rd = 1'b1;
    axi_exp_q.push_back(exp);
    axi_cyc_q.push_back(cyc + 2);
    tick();
    axi_rd = 1'b0;
  endtask

  task automatic axi_write(input logic [AAW-1:0] a, input logic [31:0] d);
    axi_addr = a; axi_wdata = d; axi_wr = 1'b1;
    tick();
    axi_wr = 1'b0;
  endtask

  task automatic axi_rw(input logic [AAW-1:0] a, input logic [31:0] d, input logic [31:0] exp);
    axi_wdata = d; axi_wr = 1'b1;
    axi_read(a, exp);
    axi_wr = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_wr_ptr"}, 64'(wr_ptr), 64'd0);
    check({tag, "_trig_ptr"}, 64'(trig_ptr), 64'd0);
    check({tag, "_wrapped"}, 64'(wrapped), 64'd0);
    check({tag, "_capturing"}, 64'(capturing), 64'd0);
    check({tag, "_frozen"}, 64'(frozen), 64'd0);
    check({tag, "_axi_rvld"}, 64'(axi_rvld), 64'd0);
    check({tag, "_axi_rdata"}, 64'(axi_rdata), 64'd0);
    check({tag, "_pb_vld"}, 64'(pb_vld), 64'd0);
    check({tag, "_pb_data"}, 64'(pb_data), 64'd0);
    check({tag, "_state"}, 64'(dbg_state), 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [TP-1:0] pv;
    tick(3);
    check_all_zero("reset");
    rst_n = 1'b1;
    tick(2);

    // Mode 1: five words then an idle-cycle trigger.
    do_arm(2'd1);
    push_word(TP'(1));
    check("m1_capturing", 64'(capturing), 64'd1);
    for (int i = 2; i <= 5; i++) push_word(TP'(i));
    trig = 1'b1; tick(); trig = 1'b0;
    tick(2);
    check("m1_frozen", 64'(frozen), 64'd1);
    check("m1_capturing_off", 64'(capturing), 64'd0);
    check("m1_wr_ptr", 64'(wr_ptr), 64'd5);
    check("m1_trig_ptr", 64'(trig_ptr), 64'd5);
    axi_read(5'd0, 32'h1);
    axi_read(5'd2, 32'h2);
    axi_read(5'd1, 32'h0);
    tick(3);

    // Slice writes while frozen, masking above the tap width, read-vs-write.
    axi_write(5'd3, 32'hFFFF_FFFF);
    axi_read(5'd3, 32'h0007_FFFF);
    axi_read(5'd2, 32'h2);
    axi_rw(5'd4, 32'h55, 32'h3);
    axi_read(5'd4, 32'h55);
    tick(3);

    // arm and trig together: capture starts, no freeze.
    post_count = AW'(3);
    pb_mode = 2'd2; arm = 1'b1; trig = 1'b1;
    tick();
    arm = 1'b0; trig = 1'b0;
    tick();
    check("coll_capturing", 64'(capturing), 64'd1);
    check("coll_frozen", 64'(frozen), 64'd0);
    check("coll_wr_ptr", 64'(wr_ptr), 64'd0);

    // Mode 2: dropped AXI write, trigger at wr_ptr 10 with a word present.
    axi_write(5'd0, 32'hDEAD);
    for (int i = 0; i < 10; i++) push_word(TP'(32'h10 + i));
    push_word(TP'(32'h1A), 1'b1);
    check("m2_trig_ptr", 64'(trig_ptr), 64'd11);
    check("m2_wr_ptr_trig", 64'(wr_ptr), 64'd11);
    push_word(TP'(32'h1B));
    check("m2_post_capturing", 64'(capturing), 64'd1);
    push_word(TP'(32'h1C), 1'b1);
    push_word(TP'(32'h1D));
    push_word(TP'(32'h1E));
    push_word(TP'(32'h1F));
    tick(2);
    check("m2_frozen", 64'(frozen), 64'd1);
    check("m2_wr_ptr", 64'(wr_ptr), 64'd14);
    check("m2_trig_ptr_hold", 64'(trig_ptr), 64'd11);
    axi_read(5'd0, 32'h10);
    axi_read(5'd20, 32'h1A);
    axi_read(5'd22, 32'h1B);
    axi_read(5'd26, 32'h1D);
    axi_read(5'd1, 32'h0);
    tick(3);

    // Wrap: 20 words into 16 entries.
    do_arm(2'd1);
    for (int i = 0; i < 20; i++) begin
      push_word(TP'(32'h100 + i));
      if (i == 14) begin
        check("wrap_pre_flag", 64'(wrapped), 64'd0);
        check("wrap_pre_ptr", 64'(wr_ptr), 64'd15);
      end
    end
    check("wrap_flag", 64'(wrapped), 64'd1);
    check("wrap_wr_ptr", 64'(wr_ptr), 64'd4);
    trig = 1'b1; tick(); trig = 1'b0;
    tick(2);
    check("wrap_frozen", 64'(frozen), 64'd1);
    axi_read(5'd0, 32'h110);
    axi_read(5'd6, 32'h113);
    axi_read(5'd8, 32'h104);
    tick(3);

    // Abort to IDLE, load entries 0..3, then play them back.
    do_arm(2'd0);
    check("abort_state", 64'(dbg_state), 64'd0);
    tick();
    check("abort_frozen", 64'(frozen), 64'd0);
    for (int e = 0; e < 4; e++) begin
      axi_write(AAW'(2 * e), 32'hA0 + e);
      axi_write(AAW'(2 * e + 1), 32'(e));
    end
    pb_last = AW'(3);
    for (int k = 0; k < 10; k++) begin
      pv = (TP'(k % 4) << 32) | TP'(32'hA0 + (k % 4));
      pb_exp_q.push_back(pv);
    end
    do_arm(2'd3);
    tick();
    check("pb_vld_early", 64'(pb_vld), 64'd0);
    tick();
    check("pb_vld_rise", 64'(pb_vld), 64'd1);
    tick(7);
    pb_mode = 2'd0;
    tick();
    check("pb_vld_exit0", 64'(pb_vld), 64'd1);
    tick();
    check("pb_vld_exit1", 64'(pb_vld), 64'd1);
    tick();
    check("pb_vld_drop", 64'(pb_vld), 64'd0);
    tick(2);

    // Reset asserted in the middle of POST.
    post_count = AW'(5);
    do_arm(2'd2);
    push_word(TP'(32'h30));
    push_word(TP'(32'h31));
    axi_read(5'd0, 32'h30);
    push_word(TP'(32'h32), 1'b1);
    push_word(TP'(32'h33));
    check("rst_pre_capturing", 64'(capturing), 64'd1);
    check("rst_pre_state", 64'(dbg_state), 64'd2);
    in_data = TP'(32'h3F); in_vld = 1'b1;
    rst_n = 1'b0;
    #1;
    check_all_zero("rst_async");
    tick(2);
    in_vld = 1'b0;
    rst_n = 1'b1;
    tick(3);
    check("rst_post_state", 64'(dbg_state), 64'd0);
    check("rst_post_wr_ptr", 64'(wr_ptr), 64'd0);

    tick(4);
    check("axi_queue_drained", 64'(axi_exp_q.size()), 64'd0);
    check("pb_queue_drained", 64'(pb_exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
